// File: rtl/calc_pkg.sv
// Shared encodings for the multi-port calculator core.
package calc_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    PEND = 2'd2
  } port_st_e;

endpackage

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter: grants one requester per cycle, searching from the port after the last grant.
module calc_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IdxW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IdxW-1:0]      gnt_idx_o
);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      cand = IdxW'((32'(last_q) + off) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  // Reset pointer to the last port so port 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= IdxW'(NUM_PORTS - 1);
    end else if (found) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/calc_multi_core.sv
// Multi-port calculator: per-port command/operand capture, one shared registered ALU,
// round-robin arbitration. Define CALC_SHIFT_EN to build the SHL/SHR shifter.
module calc_multi_core
  import calc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CMD_W*NUM_PORTS-1:0]   cmd_in,
  input  logic [WIDTH*NUM_PORTS-1:0]   data_in,
  output logic [RESP_W*NUM_PORTS-1:0]  resp_out,
  output logic [WIDTH*NUM_PORTS-1:0]   data_out
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  port_st_e         st_q  [NUM_PORTS];
  logic [CMD_W-1:0] cmd_q [NUM_PORTS];
  logic [WIDTH-1:0] op1_q [NUM_PORTS];
  logic [WIDTH-1:0] op2_q [NUM_PORTS];

  logic [NUM_PORTS-1:0][RESP_W-1:0] resp_q;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  data_q;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [IdxW-1:0]      gnt_idx;

  logic [CMD_W-1:0]  alu_cmd;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH:0]    alu_sum;
  logic [RESP_W-1:0] alu_resp;
  logic [WIDTH-1:0]  alu_data;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = (st_q[i] == PEND);
    end
  end

  calc_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IdxW      (IdxW)
  ) u_arb (
    .clk_i     (clk),
    .rst_i     (reset),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign alu_cmd = cmd_q[gnt_idx];
  assign alu_a   = op1_q[gnt_idx];
  assign alu_b   = op2_q[gnt_idx];
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

`ifdef CALC_SHIFT_EN
  localparam int unsigned ShW = $clog2(WIDTH);
`endif

  always_comb begin
    alu_resp = RESP_OK;
    alu_data = '0;
    case (alu_cmd)
      CMD_ADD: begin
        if (alu_sum[WIDTH]) alu_resp = RESP_OVF;
        else                alu_data = alu_sum[WIDTH-1:0];
      end
      CMD_SUB: begin
        if (alu_b > alu_a) alu_resp = RESP_OVF;
        else               alu_data = alu_a - alu_b;
      end
`ifdef CALC_SHIFT_EN
      CMD_SHL: alu_data = alu_a << alu_b[ShW-1:0];
      CMD_SHR: alu_data = alu_a >> alu_b[ShW-1:0];
`endif
      default: alu_resp = RESP_INV;
    endcase
  end

  // Per-port FSMs plus registered responses; only the granted port sees a nonzero response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]  <= IDLE;
        cmd_q[i] <= '0;
        op1_q[i] <= '0;
        op2_q[i] <= '0;
      end
      resp_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (st_q[i])
          IDLE: begin
            if (cmd_in[i*CMD_W +: CMD_W] != CMD_NOP) begin
              cmd_q[i] <= cmd_in[i*CMD_W +: CMD_W];
              op1_q[i] <= data_in[i*WIDTH +: WIDTH];
              st_q[i]  <= OP2;
            end
          end
          OP2: begin
            op2_q[i] <= data_in[i*WIDTH +: WIDTH];
            st_q[i]  <= PEND;
          end
          PEND: begin
            if (gnt[i]) st_q[i] <= IDLE;
          end
          default: st_q[i] <= IDLE;
        endcase
        resp_q[i] <= gnt[i] ? alu_resp : '0;
        data_q[i] <= gnt[i] ? alu_data : '0;
      end
    end
  end

  assign resp_out = resp_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_calc_multi_core.sv
// Directed self-checking bench for calc_multi_core (4 ports, 32-bit).
module tb_calc_multi_core;

  localparam int unsigned NP = 4;
  localparam int unsigned W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [4*NP-1:0]   cmd_in;
  logic [W*NP-1:0]   data_in;
  logic [2*NP-1:0]   resp_out;
  logic [W*NP-1:0]   data_out;

  int n_chk  = 0;
  int n_pass = 0;

  calc_multi_core #(
    .NUM_PORTS (NP),
    .WIDTH     (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .resp_out (resp_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [W-1:0] d);
    cmd_in[p*4 +: 4] = c;
    data_in[p*W +: W] = d;
  endtask

  function automatic logic [W-1:0] pdata(input int p);
    return data_out[p*W +: W];
  endfunction

  // One isolated transaction; checks silence at N+2, the response at N+3, silence at N+4.
  task automatic run_one(input string tag, input int p, input logic [3:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] er, input logic [W-1:0] ed);
    logic [7:0] exp_vec;
    exp_vec = 8'(er) << (2 * p);
    set_port(p, c, a);
    step();
    set_port(p, 4'd0, b);
    step();
    set_port(p, 4'd0, '0);
    check({tag, "_n2"}, 64'(resp_out), 64'd0);
    step();
    check({tag, "_resp"}, 64'(resp_out), 64'(exp_vec));
    check({tag, "_data"}, 64'(pdata(p)), 64'(ed));
    step();
    check({tag, "_n4"}, 64'(resp_out), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    cmd_in  = '0;
    data_in = '0;
    step();
    check("rst_resp", 64'(resp_out), 64'd0);
    check("rst_data", 64'(|data_out), 64'd0);
    reset = 1'b0;
    step();

    // All ports at once: grants must rotate 0..3 starting from port 0.
    for (int i = 0; i < 4; i++) set_port(i, 4'd1, 32'd1);
    step();
    for (int i = 0; i < 4; i++) set_port(i, 4'd0, 32'(i));
    step();
    for (int i = 0; i < 4; i++) set_port(i, 4'd0, '0);
    check("all4_n2", 64'(resp_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("all4_resp%0d", i), 64'(resp_out), 64'(8'h1 << (2 * i)));
      check($sformatf("all4_data%0d", i), 64'(pdata(i)), 64'(1 + i));
    end
    step();
    check("all4_end", 64'(resp_out), 64'd0);

    run_one("add37",   0, 4'd1, 32'h3,         32'h4, 2'd1, 32'h7);
    run_one("addovf",  1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
    run_one("subunf",  3, 4'd2, 32'd3,         32'd5, 2'd2, 32'h0);
    run_one("sub53",   2, 4'd2, 32'd5,         32'd3, 2'd1, 32'd2);
    run_one("inv4",    2, 4'd4, 32'd9,         32'd9, 2'd3, 32'h0);
`ifdef CALC_SHIFT_EN
    run_one("shl",     0, 4'd5, 32'd1,         32'd4,  2'd1, 32'h10);
    run_one("shr",     3, 4'd6, 32'h80,        32'h23, 2'd1, 32'h10);
`else
    run_one("shl",     0, 4'd5, 32'd1,         32'd4,  2'd3, 32'h0);
    run_one("shr",     3, 4'd6, 32'h80,        32'h23, 2'd3, 32'h0);
`endif

    // Port 1: command in PEND is ignored, command in response cycle is accepted.
    set_port(1, 4'd1, 32'd10);
    step();
    set_port(1, 4'd0, 32'd20);
    step();
    set_port(1, 4'd1, 32'd100);
    step();
    check("reiss_resp1", 64'(resp_out), 64'h4);
    check("reiss_data1", 64'(pdata(1)), 64'd30);
    set_port(1, 4'd2, 32'd50);
    step();
    set_port(1, 4'd0, 32'd8);
    step();
    set_port(1, 4'd0, '0);
    check("reiss_n5", 64'(resp_out), 64'd0);
    step();
    check("reiss_resp2", 64'(resp_out), 64'h4);
    check("reiss_data2", 64'(pdata(1)), 64'd42);
    step();
    check("reiss_end", 64'(resp_out), 64'd0);

    // Reset while port 3 responds and ports 0..2 are pending.
    set_port(3, 4'd1, 32'd5);
    step();
    set_port(3, 4'd0, 32'd6);
    for (int i = 0; i < 3; i++) set_port(i, 4'd1, 32'd7);
    step();
    set_port(3, 4'd0, '0);
    for (int i = 0; i < 3; i++) set_port(i, 4'd0, 32'd1);
    step();
    for (int i = 0; i < 3; i++) set_port(i, 4'd0, '0);
    check("prerst_resp", 64'(resp_out), 64'h40);
    check("prerst_data", 64'(pdata(3)), 64'd11);
    reset = 1'b1;
    #1;
    check("async_resp", 64'(resp_out), 64'd0);
    check("async_data", 64'(|data_out), 64'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("postrst%0d", k), 64'(resp_out), 64'd0);
    end
    run_one("postrst_add", 2, 4'd1, 32'd40, 32'd2, 2'd1, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_multi_core.md
# calc_multi_core

Parametrised multi-port integer calculator core: NUM_PORTS independent request ports share one registered ALU through a round-robin arbiter. Each port issues a two-cycle command/operand transaction and receives exactly one single-cycle response. This is the DUT-side successor to the single-port adder used in the existing calculator benches. It sits between the port stimulus drivers and the response monitors/scoreboard.

## Interface
- NUM_PORTS, 4: number of independent request ports (1..8)
- WIDTH, 32: operand/result width in bits (8..64, power of two)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_in  in  4*NUM_PORTS  per-port command; port i uses bits [4i+3:4i]
- data_in  in  WIDTH*NUM_PORTS  per-port operand bus
- resp_out  out  2*NUM_PORTS  per-port response code; 0 = none
- data_out  out  WIDTH*NUM_PORTS  per-port result; valid only when the matching resp_out is nonzero

## Operation
- Commands: 1 = ADD, 2 = SUB, 5 = SHL, 6 = SHR. 0 = idle. All other values are invalid.
- Responses: 1 = success, 2 = overflow/underflow, 3 = invalid command.
- Transaction on port i:
  - cycle N: cmd_in nonzero, data_in = op1.
  - cycle N+1: data_in = op2. cmd_in is ignored in this cycle.
- Per-port state: IDLE -> OP2 (after cmd capture) -> PEND (after op2 capture) -> IDLE (on grant).
- cmd_in is ignored while the port is in OP2 or PEND. There is no queueing, and ignored commands produce no response.
- Arbiter:
  - Each cycle it grants one PEND port, round-robin, starting from the port after the last grant.
  - After reset, the last-grant pointer is NUM_PORTS-1, so port 0 has first priority.
- ADD: result = op1+op2.
  - Carry out of WIDTH bits -> resp 2, data 0.
- SUB: result = op1-op2, unsigned.
  - If op2 > op1 -> resp 2, data 0.
- SHL/SHR: logical shift of op1 by op2[$clog2(WIDTH)-1:0]. Upper op2 bits are ignored.
  - Always resp 1.
- Invalid command: operands are still collected and arbitrated as normal -> resp 3, data 0.
- Outside its response cycle, each port drives resp_out = 0 and data_out = 0.

## Timing
- Reset values:
  - all resp_out = 0, all data_out = 0
  - all ports IDLE
  - last-grant pointer = NUM_PORTS-1
- Reset takes effect immediately (asynchronous) and aborts in-flight transactions. No responses are issued for them after reset is released.
- Minimum latency: cmd in cycle N -> response in cycle N+3. Breakdown:
  - op2 captured at the end of N+1
  - grant and ALU evaluation in N+2
  - result registered at the end of N+2
- Each extra cycle waiting for arbitration adds one cycle of latency.
- Worst-case latency: N+2+NUM_PORTS.
- Responses last exactly one cycle.
- A port becomes IDLE at the grant edge. A new cmd_in in the response cycle (N+3) is accepted.
- Throughput: one response per cycle across all ports, and at most one response per cycle in total.
- Simultaneous PEND on all ports: grants rotate 0,1,...,NUM_PORTS-1. Responses appear in consecutive cycles.

## Configuration
- CALC_SHIFT_EN
  - Defined: SHL/SHR are implemented as above.
  - Not defined: shifter logic is removed, and commands 5/6 are treated as invalid (resp 3, data 0).
  - All other behaviour and timing are identical in both builds.

## Structure
- Package calc_pkg holds:
  - CMD_W = 4 and RESP_W = 2
  - command encodings CMD_NOP/ADD/SUB/SHL/SHR
  - response encodings RESP_NONE/OK/OVF/INV
  - port-state enum IDLE/OP2/PEND
- Sub-module calc_rr_arbiter, parametrised on NUM_PORTS:
  - inputs: request vector, clk/reset
  - outputs: one-hot grant plus grant index
  - owns the last-grant pointer

## Test plan
- Port 0, ADD 0x0000_0003 + 0x0000_0004 -> resp_out[0] = 1, data_out = 0x7, exactly 3 cycles after cmd, for one cycle.
- ADD 0xFFFF_FFFF + 1 -> resp 2, data 0. SUB 3 - 5 -> resp 2, data 0. SUB 5 - 3 -> resp 1, data 2.
- All 4 ports issue ADD 1+i in the same cycle N -> responses on ports 0,1,2,3 in cycles N+3..N+6, each with data 1+i.
- Command 4 on port 2 -> resp 3, data 0. With CALC_SHIFT_EN undefined, SHL 1 by 4 -> resp 3. With it defined, SHL 1 by 4 -> resp 1, data 0x10.
- Port 1 issues a second cmd at N+2 (ignored, no response) and another at N+3. The N+3 command gets a response at N+6.
- Assert reset at N+2 with 3 ports pending -> all outputs 0 immediately, and no responses after release.
